// File: rtl/losaias_seg_counter_if.sv
// Pad-side bundle of the seven-segment counter: dedicated inputs, bidir inputs,
// the segment outputs and the bidir output/enable lines.
interface losaias_seg_counter_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/losaias_seg_counter.sv
// Single seven-segment digit stepping 0-9 or 0-F at a rate of
// (ui_in+1)*PRESCALE cycles, with pause, direction and hex-mode controls.
module losaias_seg_counter #(
  parameter int PRESCALE = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  losaias_seg_counter_if.slave io
);

  localparam int              PC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRESCALE - 1);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      sc_q, sc_d;
  logic [3:0]      digit_q, digit_d;
  logic            dp_q, dp_d;
  logic [3:0]      digit_adv;
  logic            step;
  logic            advance;

  logic pause, down, hex;
  assign pause = io.uio_in[0];
  assign down  = io.uio_in[1];
  assign hex   = io.uio_in[2];

  logic unused_inputs;
  assign unused_inputs = &{1'b0, io.ena, io.uio_in[7:3]};

  // Out-of-range digits (left behind when hex mode is dropped) resolve to the
  // decimal end value in the direction of travel.
  always_comb begin
    digit_adv = digit_q;
    if (hex) begin
      digit_adv = down ? (digit_q - 4'd1) : (digit_q + 4'd1);
    end else if (down) begin
      digit_adv = ((digit_q == 4'd0) || (digit_q > 4'd9)) ? 4'd9 : (digit_q - 4'd1);
    end else begin
      digit_adv = (digit_q >= 4'd9) ? 4'd0 : (digit_q + 4'd1);
    end
  end

  always_comb begin
    pc_d    = pc_q;
    sc_d    = sc_q;
    digit_d = digit_q;
    dp_d    = dp_q;
    step    = 1'b0;
    advance = 1'b0;
    if (!pause) begin
      step = (pc_q == PC_LAST);
      pc_d = step ? '0 : (pc_q + PC_W'(1));
      // ">=" lets a lowered ui_in take effect on the very next step.
      if (step) begin
        if (sc_q >= io.ui_in) begin
          sc_d    = '0;
          advance = 1'b1;
        end else begin
          sc_d = sc_q + 8'd1;
        end
      end
    end
    if (advance) begin
      digit_d = digit_adv;
      dp_d    = ~dp_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      sc_q    <= '0;
      digit_q <= '0;
      dp_q    <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      sc_q    <= sc_d;
      digit_q <= digit_d;
      dp_q    <= dp_d;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;
      4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;
      default: seg7 = 7'h71;
    endcase
  endfunction

  assign io.uo_out  = {dp_q, seg7(digit_q)};
  assign io.uio_out = {4'b0000, digit_q};
  assign io.uio_oe  = 8'h0F;

endmodule

// File: tb/tb_losaias_seg_counter.sv
// Randomized and directed checks of the seven-segment counter against a
// cycle-counting reference model.
module tb_losaias_seg_counter;
  localparam int P = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  losaias_seg_counter_if bus();

  losaias_seg_counter #(.PRESCALE(P)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model: count unpaused cycles; every P-th is a step; count steps since last advance.
  int   m_cyc;
  int   m_steps;
  int   m_digit;
  bit   m_dp;
  logic [7:0] m_uo;
  logic [7:0] m_uio;

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_cyc = 0; m_steps = 0; m_digit = 0; m_dp = 1'b0;
    end else if (!bus.uio_in[0]) begin
      m_cyc++;
      if (m_cyc % P == 0) begin
        if (m_steps >= int'(bus.ui_in)) begin
          m_steps = 0;
          if (bus.uio_in[2])
            m_digit = bus.uio_in[1] ? (m_digit + 15) % 16 : (m_digit + 1) % 16;
          else if (bus.uio_in[1])
            m_digit = (m_digit == 0 || m_digit > 9) ? 9 : m_digit - 1;
          else
            m_digit = (m_digit >= 9) ? 0 : m_digit + 1;
          m_dp = !m_dp;
        end else begin
          m_steps++;
        end
      end
    end
    m_uo  = {m_dp, seg_tbl[m_digit]};
    m_uio = 8'(m_digit);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.ui_in = 8'd0; bus.uio_in = 8'd0;
    rst = 1'b1;
    for (int e = 0; e < 3; e++) begin
      tick();
      vectors++;
      if (bus.uo_out !== 8'h3F || bus.uio_out !== 8'h00 || bus.uio_oe !== 8'h0F) begin
        errors++;
        $display("FAIL reset cyc%0d: uo=%h uio=%h oe=%h, required uo=3f uio=00 oe=0f",
                 e, bus.uo_out, bus.uio_out, bus.uio_oe);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_up();
    bus.ui_in = 8'd0; bus.uio_in = 8'd0;
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      tick();
      vectors++;
      if (bus.uo_out !== m_uo || bus.uio_out !== m_uio) begin
        errors++;
        $display("FAIL basic_up edge%0d: uo=%h uio=%h, required uo=%h uio=%h",
                 e, bus.uo_out, bus.uio_out, m_uo, m_uio);
      end
      if (e == 4 || e == 40) begin
        vectors++;
        if (bus.uo_out !== ((e == 4) ? 8'h86 : 8'h3F)) begin
          errors++;
          $display("FAIL basic_up_fixed edge%0d: uo=%h, required %h",
                   e, bus.uo_out, (e == 4) ? 8'h86 : 8'h3F);
        end
      end
    end
  endtask

  task automatic test_rate_select();
    bus.ui_in = 8'd2; bus.uio_in = 8'd0;
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      tick();
      vectors++;
      if (bus.uio_out !== ((e < 12) ? 8'd0 : 8'd1) || bus.uo_out !== m_uo) begin
        errors++;
        $display("FAIL rate2 edge%0d: uio=%h uo=%h, required uio=%h uo=%h",
                 e, bus.uio_out, bus.uo_out, (e < 12) ? 8'd0 : 8'd1, m_uo);
      end
    end
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 5) bus.ui_in = 8'd0;
      vectors++;
      if (bus.uio_out !== ((e < 8) ? 8'd0 : 8'd1) || bus.uo_out !== m_uo) begin
        errors++;
        $display("FAIL rate_drop edge%0d: uio=%h uo=%h, required uio=%h uo=%h",
                 e, bus.uio_out, bus.uo_out, (e < 8) ? 8'd0 : 8'd1, m_uo);
      end
    end
  endtask

  task automatic test_down_hex();
    bus.ui_in = 8'd0; bus.uio_in = 8'h06;
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      tick();
      vectors++;
      if (bus.uo_out !== m_uo || bus.uio_out !== m_uio) begin
        errors++;
        $display("FAIL down_hex edge%0d: uo=%h uio=%h, required uo=%h uio=%h",
                 e, bus.uo_out, bus.uio_out, m_uo, m_uio);
      end
      if (e == 4 || e == 8) begin
        vectors++;
        if (bus.uo_out[6:0] !== ((e == 4) ? 7'h71 : 7'h79)) begin
          errors++;
          $display("FAIL down_hex_seg edge%0d: seg=%h, required %h",
                   e, bus.uo_out[6:0], (e == 4) ? 7'h71 : 7'h79);
        end
      end
    end
  endtask

  task automatic test_pause();
    bus.ui_in = 8'd1; bus.uio_in = 8'd0;
    do_reset();
    for (int e = 1; e <= 5; e++) tick();
    bus.uio_in = 8'h01;
    for (int e = 1; e <= 20; e++) begin
      tick();
      vectors++;
      if (bus.uo_out !== 8'h3F || bus.uio_out !== 8'h00) begin
        errors++;
        $display("FAIL pause_hold cyc%0d: uo=%h uio=%h, required uo=3f uio=00",
                 e, bus.uo_out, bus.uio_out);
      end
    end
    bus.uio_in = 8'h00;
    for (int e = 1; e <= 11; e++) begin
      tick();
      vectors++;
      if (bus.uio_out !== ((e < 3) ? 8'd0 : (e < 11) ? 8'd1 : 8'd2) || bus.uo_out !== m_uo) begin
        errors++;
        $display("FAIL pause_resume edge%0d: uio=%h uo=%h, required uio=%h uo=%h",
                 e, bus.uio_out, bus.uo_out, m_uio, m_uo);
      end
    end
  endtask

  task automatic test_mid_reset();
    bus.ui_in = 8'd0; bus.uio_in = 8'd0;
    do_reset();
    for (int e = 1; e <= 20; e++) tick();
    vectors++;
    if (bus.uio_out !== 8'd5) begin
      errors++;
      $display("FAIL mid_reset_pre: uio=%h, required 05", bus.uio_out);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (bus.uo_out !== 8'h3F || bus.uio_out !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: uo=%h uio=%h, required uo=3f uio=00", bus.uo_out, bus.uio_out);
    end
    for (int e = 1; e <= 4; e++) begin
      tick();
      vectors++;
      if (bus.uio_out !== ((e < 4) ? 8'd0 : 8'd1)) begin
        errors++;
        $display("FAIL mid_reset_restart edge%0d: uio=%h, required %h",
                 e, bus.uio_out, (e < 4) ? 8'd0 : 8'd1);
      end
    end
  endtask

  task automatic test_random();
    bus.ui_in = 8'd0; bus.uio_in = 8'd0;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 15) == 0) bus.ui_in = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 20) == 0)
        bus.uio_in = {5'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0)};
      rst = ($urandom_range(0, 299) == 0);
      tick();
      vectors++;
      if (bus.uo_out !== m_uo || bus.uio_out !== m_uio || bus.uio_oe !== 8'h0F) begin
        errors++;
        $display("FAIL random cyc%0d: uo=%h uio=%h oe=%h, required uo=%h uio=%h oe=0f",
                 c, bus.uo_out, bus.uio_out, bus.uio_oe, m_uo, m_uio);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.ena = 1'b1;
    bus.ui_in = 8'd0;
    bus.uio_in = 8'd0;
    m_cyc = 0; m_steps = 0; m_digit = 0; m_dp = 1'b0;
    m_uo = 8'h3F; m_uio = 8'h00;
    test_reset();
    test_basic_up();
    test_rate_select();
    test_down_hex();
    test_pause();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
